// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch sequencer around the fetch PC of the MIPS core.
// Issues req/ack reads to instruction memory, buffers one instruction for
// decode with stall back-pressure, and applies exception / branch / jump
// redirects. A read already on the bus when a redirect arrives cannot be
// abandoned, so it is completed in DRAIN and its data thrown away.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    output logic [31:0] pc_o,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HAVE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        misalign_q;

    logic        redir_s;
    logic        misalign_s;
    logic [31:0] target_s;

    // Redirect decode: exception beats a misaligned target, which beats a plain redirect.
    always_comb begin
        redir_s    = exc | redirect_valid;
        misalign_s = ~exc & redirect_valid & (redirect_pc[1:0] != 2'b00);
        if (exc || misalign_s) begin
            target_s = EXC_VECTOR;
        end else begin
            target_s = redirect_pc;
        end
    end

    // Next-state logic for the fetch FSM, PC and the decode buffer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            FETCH: begin
                if (redir_s) begin
                    // A completing read is simply dropped; a pending one must drain.
                    pc_d = target_s;
                    if (imem_ack) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = HAVE;
                end else begin
                    state_d = FETCH;
                end
            end
            HAVE: begin
                if (redir_s) begin
                    // Flush the buffered instruction even if decode is stalled.
                    valid_d = 1'b0;
                    pc_d    = target_s;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else begin
                    state_d = HAVE;
                end
            end
            DRAIN: begin
                if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Bus address follows the new PC when a fetch starts and is frozen otherwise (DRAIN keeps the old one).
    always_comb begin
        if (state_d == FETCH) begin
            addr_d = pc_d;
        end else begin
            addr_d = addr_q;
        end
        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    // State and output registers; reset drops any outstanding memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            req_q      <= 1'b0;
            instr_q    <= 32'h0000_0000;
            ipc_q      <= 32'h0000_0000;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_s;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_valid  = valid_q;
    assign instr        = instr_q;
    assign instr_pc     = ipc_q;
    assign pc_o         = pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios followed by
// randomized memory latency, stalls, redirects, exceptions and resets, all
// compared against a transaction-level reference model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc;
    logic [31:0] pc_o;
    logic        misalign_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a started flag, an outstanding read (possibly stale),
    // and a one-entry decode buffer.
    bit          m_started;
    bit          m_inflight;
    bit          m_stale;
    bit          m_valid;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    pc_fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc            (exc),
        .pc_o           (pc_o),
        .misalign_err   (misalign_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_started  = 1'b0;
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_valid    = 1'b0;
        m_mis      = 1'b0;
        m_pc       = RESET_VEC;
        m_addr     = RESET_VEC;
        m_instr    = 32'h0000_0000;
        m_ipc      = 32'h0000_0000;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void m_edge();
        bit          redir;
        bit          mis;
        logic [31:0] tgt;
        redir = exc || redirect_valid;
        mis   = !exc && redirect_valid && (redirect_pc[1:0] != 2'b00);
        tgt   = (exc || mis) ? EXC_VEC : redirect_pc;
        if (!m_started) begin
            m_started  = 1'b1;
            m_inflight = 1'b1;
            m_stale    = 1'b0;
            if (redir) m_pc = tgt;
            m_addr = m_pc;
        end else if (m_inflight) begin
            if (imem_ack && !m_stale && !redir) begin
                m_valid    = 1'b1;
                m_instr    = imem_rdata;
                m_ipc      = m_addr;
                m_pc       = m_addr + 32'd4;
                m_inflight = 1'b0;
            end else if (imem_ack) begin
                if (redir) m_pc = tgt;
                m_stale = 1'b0;
                m_addr  = m_pc;
            end else if (redir) begin
                m_pc    = tgt;
                m_stale = 1'b1;
            end
        end else if (m_valid) begin
            if (redir || !stall) begin
                m_valid = 1'b0;
                if (redir) m_pc = tgt;
                m_inflight = 1'b1;
                m_stale    = 1'b0;
                m_addr     = m_pc;
            end
        end
        m_mis = mis;
    endfunction

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_inflight});
        if (m_inflight) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("pc_o", pc_o, m_pc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    task automatic tick();
        m_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0000_0000;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        exc            = 1'b0;
    endtask

    task automatic drive_random(input int ack_pct, input int stall_pct, input int redir_pct);
        logic [31:0] r;
        int          sel;
        imem_ack       = m_inflight && (int'($urandom_range(99)) < ack_pct);
        imem_rdata     = $urandom;
        stall          = int'($urandom_range(99)) < stall_pct;
        exc            = int'($urandom_range(99)) < (redir_pct / 4);
        redirect_valid = int'($urandom_range(99)) < redir_pct;
        r   = $urandom;
        sel = int'($urandom_range(3));
        case (sel)
            0: r[1:0] = 2'b00;
            1: if (exc) r[1:0] = 2'b00; else if (r[1:0] == 2'b00) r[1:0] = 2'b10;
            2: r = 32'hFFFF_FFFC;
            default: r = 32'h0000_0100;
        endcase
        redirect_pc = r;
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_VEC);
        chk("rst_pc", pc_o, RESET_VEC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_ipc", instr_pc, 32'h0000_0000);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        m_reset();
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        check_all();
    endtask

    // Directed scenarios, then a long randomized run.
    initial begin
        drive_idle();
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        do_reset();

        // Zero-wait memory, no stall: 0x0, 0x4, 0x8 on alternate cycles.
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            imem_ack   = m_inflight;
            imem_rdata = $urandom;
            tick();
            if (i == 5) chk("pc_after_3", pc_o, 32'h0000_000C);
        end

        // Stall three cycles while holding an instruction.
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            stall = 1'b1;
            tick();
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end

        // Redirect to the top of memory, then one ack wraps the PC.
        drive_idle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        drive_idle();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Misaligned redirect while stalled in HAVE.
        drive_idle();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        chk("mis_flush", {31'd0, instr_valid}, 32'd0);
        drive_idle();
        tick();
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);
        chk("mis_addr", imem_addr, EXC_VEC);

        // Redirect while a read is pending, then reset in DRAIN.
        drive_idle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        chk("drain_addr", imem_addr, EXC_VEC);
        chk("drain_pc", pc_o, 32'h0000_0100);
        do_reset();
        drive_idle();
        tick();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, RESET_VEC);

        // Randomized traffic with varying memory latency, stall and redirect rates.
        for (int blk = 0; blk < 40; blk++) begin
            int ack_pct;
            int stall_pct;
            int redir_pct;
            ack_pct   = 20 + int'($urandom_range(80));
            stall_pct = int'($urandom_range(60));
            redir_pct = int'($urandom_range(25));
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(499) == 0) begin
                    do_reset();
                end else begin
                    drive_random(ack_pct, stall_pct, redir_pct);
                    tick();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
